// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one combinational sprite palette between NUM_REQ requesters,
// followed by a two-stage registered pipeline with downstream backpressure.
module palette_lookup_arbiter #(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned IDX_W           = 8,
   parameter int unsigned ID_W            = $clog2(NUM_REQ),
   parameter int unsigned TRANSPARENT_IDX = 0
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*IDX_W-1:0] req_index,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [IDX_W-1:0]         pal_index,
   input  logic [11:0]              pal_rgb,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [11:0]              rsp_rgb,
   output logic                     rsp_transparent
);

   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  s1_id;
   logic             s1_valid;
   logic             s1_en;
   logic             s2_en;
   logic             found;
   logic             grant;
   logic [ID_W-1:0]  winner;
   logic [ID_W:0]    cand;
   logic [ID_W-1:0]  next_ptr;
   logic [IDX_W-1:0] winner_index;

   assign s2_en = !rsp_valid || rsp_ready;
   assign s1_en = !s1_valid || s2_en;

   // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ; first valid one wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (!found && req_valid[cand[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[ID_W-1:0];
         end
      end
   end

   // No grant while stalled or in reset, so nothing is accepted that would be dropped.
   assign grant        = found && s1_en && !Reset;
   assign req_ready    = grant ? (NUM_REQ'(1) << winner) : '0;
   assign winner_index = req_index[winner*IDX_W +: IDX_W];
   assign next_ptr     = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rr_ptr    <= '0;
         s1_valid  <= 1'b0;
         s1_id     <= '0;
         pal_index <= '0;
      end else begin
         if (grant) begin
            rr_ptr <= next_ptr;
         end
         if (s1_en) begin
            s1_valid <= grant;
            if (grant) begin
               pal_index <= winner_index;
               s1_id     <= winner;
            end
         end
      end
   end

   // Palette answers combinationally for pal_index, so the colour is captured alongside its tag.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rsp_valid       <= 1'b0;
         rsp_rgb         <= '0;
         rsp_id          <= '0;
         rsp_transparent <= 1'b0;
      end else if (s2_en) begin
         rsp_valid       <= s1_valid;
         rsp_rgb         <= pal_rgb;
         rsp_id          <= s1_id;
         rsp_transparent <= (pal_index == IDX_W'(TRANSPARENT_IDX));
      end
   end

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed bench for palette_lookup_arbiter with a scoreboard of expected responses
// filled at each handshake and drained as results leave the pipeline.
module tb_palette_lookup_arbiter;

   logic        Clk;
   logic        Reset;
   logic [3:0]  req_valid;
   logic [31:0] req_index;
   logic [3:0]  req_ready;
   logic [7:0]  pal_index;
   logic [11:0] pal_rgb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [11:0] rsp_rgb;
   logic        rsp_transparent;

   int checks   = 0;
   int failures = 0;
   int rspCount = 0;

   logic [14:0] sbq[$];
   logic [14:0] sbExp;
   logic [7:0]  sbIdx;

   palette_lookup_arbiter #(
      .NUM_REQ(4), .IDX_W(8), .ID_W(2), .TRANSPARENT_IDX(0)
   ) dut (
      .Clk(Clk), .Reset(Reset),
      .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
      .pal_index(pal_index), .pal_rgb(pal_rgb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_rgb(rsp_rgb), .rsp_transparent(rsp_transparent)
   );

   // Turret-style palette: index 5 is 12'h782, index 0 is black, the rest a fixed scramble.
   function automatic logic [11:0] palModel(input logic [7:0] idx);
      case (idx)
         8'h00:   palModel = 12'h000;
         8'h05:   palModel = 12'h782;
         default: palModel = {idx[7:4] ^ 4'h3, idx[3:0], ~idx[3:0]};
      endcase
   endfunction

   assign pal_rgb = palModel(pal_index);

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Runs one cycle: samples the grant mid-cycle, then retires handshaken requesters.
   task automatic applyStimulus(output logic [3:0] grant);
      @(negedge Clk);
      grant = req_valid & req_ready;
      @(posedge Clk);
      #1;
      req_valid = req_valid & ~grant;
   endtask

   // Scoreboard: pop on every delivered result, push on every handshake, flush on reset.
   always @(negedge Clk) begin
      if (Reset) begin
         sbq.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            checks++;
            assert (sbq.size() != 0) else begin
               failures++;
               $error("[TB] FAIL sb_unexpected: got id=%0d rgb=%03h expected no response", rsp_id, rsp_rgb);
            end
            if (sbq.size() != 0) begin
               sbExp = sbq.pop_front();
               checkOutput("sb_rsp", {17'd0, rsp_id, rsp_transparent, rsp_rgb}, {17'd0, sbExp});
               rspCount++;
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               sbIdx = req_index[i*8 +: 8];
               sbq.push_back({2'(i), sbIdx == 8'h00, palModel(sbIdx)});
            end
         end
      end
   end

   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   logic [3:0]  g;
   int          hs;
   logic        haveSnap;
   logic [14:0] snap;
   logic [3:0]  bpGrant [5] = '{4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};

   initial begin
      Reset     = 1'b1;
      req_valid = 4'b1111;
      req_index = {8'h3c, 8'h2b, 8'h1a, 8'h09};
      rsp_ready = 1'b1;

      $display("[TB] reset with all requesters valid");
      repeat (2) begin
         @(negedge Clk);
         checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
         checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      end
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      checkOutput("rst_pal_index", 32'(pal_index), 32'h0);
      checkOutput("rst_rsp_rgb", 32'(rsp_rgb), 32'h0);
      checkOutput("rst_rsp_id", 32'(rsp_id), 32'h0);
      checkOutput("rst_rsp_transparent", 32'(rsp_transparent), 32'h0);

      $display("[TB] round-robin with all requesters valid");
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         checkOutput("rr_grant", 32'(req_ready), 32'(4'b0001 << (i % 4)));
         @(posedge Clk);
         #1;
      end
      req_valid = 4'b0000;
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("rr_rsp_count", 32'(rspCount), 32'd8);

      $display("[TB] single request from requester 2");
      req_index[2*8 +: 8] = 8'h05;
      req_valid = 4'b0100;
      applyStimulus(g);
      checkOutput("single_grant", 32'(g), 32'b0100);
      checkOutput("single_n1_valid", 32'(rsp_valid), 32'h0);
      @(posedge Clk);
      #1;
      checkOutput("single_n2_valid", 32'(rsp_valid), 32'h1);
      checkOutput("single_id", 32'(rsp_id), 32'd2);
      checkOutput("single_rgb", 32'(rsp_rgb), 32'h782);
      checkOutput("single_transparent", 32'(rsp_transparent), 32'h0);
      repeat (2) @(posedge Clk);
      #1;

      $display("[TB] transparent index from requester 1");
      req_index[1*8 +: 8] = 8'h00;
      req_valid = 4'b0010;
      applyStimulus(g);
      checkOutput("transp_grant", 32'(g), 32'b0010);
      @(posedge Clk);
      #1;
      checkOutput("transp_valid", 32'(rsp_valid), 32'h1);
      checkOutput("transp_flag", 32'(rsp_transparent), 32'h1);
      checkOutput("transp_id", 32'(rsp_id), 32'd1);
      checkOutput("transp_rgb", 32'(rsp_rgb), 32'h000);
      repeat (2) @(posedge Clk);
      #1;

      $display("[TB] backpressure with three pending requesters");
      req_index = {8'h77, 8'h42, 8'h31, 8'h05};
      req_valid = 4'b1011;
      rsp_ready = 1'b0;
      hs        = 0;
      haveSnap  = 1'b0;
      snap      = '0;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(g);
         checkOutput("bp_grant", 32'(g), 32'(bpGrant[c]));
         if (g != 4'b0000) hs++;
         if (rsp_valid) begin
            if (!haveSnap) begin
               snap     = {rsp_id, rsp_transparent, rsp_rgb};
               haveSnap = 1'b1;
               checkOutput("bp_head_id", 32'(rsp_id), 32'd3);
            end else begin
               checkOutput("bp_stable", 32'({rsp_id, rsp_transparent, rsp_rgb}), 32'(snap));
            end
         end
      end
      checkOutput("bp_handshakes", 32'(hs), 32'd2);
      checkOutput("bp_held_valid", 32'(rsp_valid), 32'h1);
      rsp_ready = 1'b1;
      applyStimulus(g);
      checkOutput("bp_release_grant", 32'(g), 32'b0010);
      repeat (4) @(posedge Clk);
      #1;
      checkOutput("bp_rsp_count", 32'(rspCount), 32'd13);

      $display("[TB] reset while both stages hold results");
      req_index = {8'h11, 8'h22, 8'h33, 8'h44};
      req_valid = 4'b0101;
      rsp_ready = 1'b0;
      applyStimulus(g);
      checkOutput("mf_grant0", 32'(g), 32'b0100);
      applyStimulus(g);
      checkOutput("mf_grant1", 32'(g), 32'b0001);
      checkOutput("mf_pre_valid", 32'(rsp_valid), 32'h1);
      Reset     = 1'b1;
      req_valid = 4'b0000;
      @(posedge Clk);
      #1;
      Reset     = 1'b0;
      rsp_ready = 1'b1;
      checkOutput("mf_drop_valid", 32'(rsp_valid), 32'h0);
      repeat (5) begin
         @(posedge Clk);
         #1;
         checkOutput("mf_no_stale", 32'(rsp_valid), 32'h0);
      end

      checkOutput("sb_empty", 32'(sbq.size()), 32'd0);
      checkOutput("total_rsp_count", 32'(rspCount), 32'd13);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
